// File: rtl/cnt_pkg.sv
// Shared types and digit-chain increment helpers for the shared counter block.
package cnt_pkg;

  // Upper bound on digits per channel supported by the increment helpers.
  localparam int MAX_SEGMENTS = 8;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Digit 0 is the least significant digit.
  typedef digit_t digit_arr_t [MAX_SEGMENTS];

  // Binary increment over the low n digits; digits at or above n pass through.
  function automatic void hex_inc(input digit_arr_t d, input int n, output digit_arr_t q);
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      q[i] = d[i];
      if (i < n && carry) begin
        q[i]  = d[i] + 4'd1;
        carry = (d[i] == 4'hF);
      end
    end
  endfunction

  // BCD ripple increment over the low n digits: 9 + carry -> 0, carry continues.
  function automatic void bcd_inc(input digit_arr_t d, input int n, output digit_arr_t q);
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      q[i] = d[i];
      if (i < n && carry) begin
        if (d[i] == 4'd9) begin
          q[i] = 4'd0;
        end else begin
          q[i]  = d[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

endpackage

// File: rtl/cnt_share_ctrl_rr_arbiter.sv
// Round-robin picker: one-hot winner from req, priority pointer advances
// to the channel after the winner whenever the FSM accepts a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);

  logic [IDXW-1:0] ptr;

  // Scan from the priority pointer upward, wrapping, and take the first request.
  always_comb begin
    int   c;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[IDXW'(c)]) begin
        found             = 1'b1;
        gnt[IDXW'(c)]     = 1'b1;
        gnt_idx           = IDXW'(c);
      end
    end
  end

  // Priority pointer: channel after the one just accepted becomes top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/cnt_share_ctrl.sv
// Shared hex/decimal incrementer time-multiplexed across NUM_REQ button
// channels. Each request is a 3-cycle read-modify-write (IDLE/CALC/WRITE);
// clears are immediate and abort an in-flight update of the same channel.
module cnt_share_ctrl
  import cnt_pkg::*;
#(
  parameter string MODE         = "HEX",
  parameter int    NUM_SEGMENTS = 4,
  parameter int    NUM_REQ      = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         req_pulse,
  input  logic [NUM_REQ-1:0]                         clr_pulse,
  output logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0]  encoded,
  output logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0]       digit_point,
  output logic [NUM_REQ-1:0]                         grant,
  output logic [NUM_REQ-1:0]                         pending,
  output logic [NUM_REQ-1:0]                         dropped
);

  localparam int IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit IS_DEC = (MODE == "DEC");

  state_t                            state;
  logic [IDXW-1:0]                   gnt_idx;
  logic [NUM_SEGMENTS-1:0][3:0]      operand_r;
  logic [NUM_SEGMENTS-1:0][3:0]      result_r;
  logic [NUM_SEGMENTS-1:0][3:0]      inc_val;

  logic [NUM_REQ-1:0]                arb_req;
  logic [NUM_REQ-1:0]                win_onehot;
  logic [IDXW-1:0]                   win_idx;
  logic                              accept;
  logic [NUM_REQ-1:0]                served;
  logic                              abort;

  // A channel being cleared this cycle cannot win: its pending bit is going
  // away and its count is being zeroed, so an increment would be stale.
  assign arb_req = pending & ~clr_pulse;
  assign accept  = (state == IDLE) && (|arb_req);
  assign served  = accept ? win_onehot : '0;
  assign abort   = (state != IDLE) && clr_pulse[gnt_idx];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .accept  (accept),
    .gnt     (win_onehot),
    .gnt_idx (win_idx)
  );

  // Increment of the latched operand, digit chain selected by MODE.
  always_comb begin
    digit_arr_t d_in;
    digit_arr_t d_out;
    d_in    = '{default: '0};
    d_out   = '{default: '0};
    inc_val = '0;
    for (int i = 0; i < NUM_SEGMENTS; i++) d_in[i] = operand_r[i];
    if (IS_DEC) bcd_inc(d_in, NUM_SEGMENTS, d_out);
    else        hex_inc(d_in, NUM_SEGMENTS, d_out);
    for (int i = 0; i < NUM_SEGMENTS; i++) inc_val[i] = d_out[i];
  end

  // Sequencer plus count register file; clears are applied last so they win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      grant       <= '0;
      operand_r   <= '0;
      result_r    <= '0;
      encoded     <= '0;
      digit_point <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_idx   <= win_idx;
            operand_r <= encoded[win_idx];
            grant     <= win_onehot;
            state     <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            result_r <= inc_val;
            state    <= WRITE;
          end
        end
        WRITE: begin
          grant <= '0;
          state <= IDLE;
          if (!abort) begin
            encoded[gnt_idx]        <= result_r;
            digit_point             <= '1;
            digit_point[gnt_idx][0] <= 1'b0;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_pulse[i]) encoded[i] <= '0;
      end
    end
  end

  // Request latch per channel; a new pulse beats the service clear, and a
  // pulse landing on an already-pending channel is lost but remembered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      dropped <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_pulse[i]) begin
          pending[i] <= 1'b0;
          dropped[i] <= 1'b0;
        end else if (req_pulse[i]) begin
          if (pending[i] && !served[i]) dropped[i] <= 1'b1;
          pending[i] <= 1'b1;
        end else if (served[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
